z80_shared_ram_arb: RTL and testbench

- Arbitrates one single-port sound work RAM between the sound Z80 and a host port (main-CPU mailbox/DMA side).
- Decodes the Z80 RAM window and stretches Z80 memory cycles with nWAIT until its access completes.
- Grants host accesses through a REQ/ACK handshake.
- Sits between the Z80 CPU wrapper's bus (SDA/SDD/nMREQ/nRD/nWR/nWAIT) and the RAM macro.

---
 rtl/z80_shared_ram_arb.sv | 190 +++++++++++++++++++
 tb/tb_z80_shared_ram_arb.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_shared_ram_arb.sv
// z80_shared_ram_arb: shares one single-port sound work RAM between the sound Z80
// and a host (mailbox/DMA) port. Z80 cycles into the 2^AW window at BASE are stretched
// with nWAIT until their RAM access completes; the host uses a level REQ / pulse ACK.
// Optional macro ARB_RR_EN: round-robin tie-break between Z80 and host. When it is
// undefined the Z80 always wins a tie.
module z80_shared_ram_arb #(
    parameter int          AW      = 11,
    parameter logic [15:0] BASE    = 16'hF800,
    parameter int          RAM_LAT = 1
) (
    input  logic          CLK,
    input  logic          nRESET,
    input  logic [15:0]   SDA,
    input  logic [7:0]    SDD_OUT,
    input  logic          nMREQ,
    input  logic          nRD,
    input  logic          nWR,
    output logic [7:0]    SDD_RAM,
    output logic          RAM_SEL,
    output logic          nWAIT,
    input  logic          HOST_REQ,
    input  logic          HOST_WE,
    input  logic [AW-1:0] HOST_A,
    input  logic [7:0]    HOST_DO,
    output logic [7:0]    HOST_DI,
    output logic          HOST_ACK,
    output logic [AW-1:0] RAM_A,
    output logic [7:0]    RAM_D,
    input  logic [7:0]    RAM_Q,
    output logic          RAM_CE,
    output logic          RAM_WE
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RAM_LAT);

    state_t        state_reg, state_next;
    logic [2:0]    cnt_reg, cnt_next;
    logic          grant_z_reg, grant_z_next;     // current access belongs to the Z80
    logic          grant_we_reg, grant_we_next;   // current access is a write
    logic [AW-1:0] ram_a_reg, ram_a_next;
    logic [7:0]    ram_d_reg, ram_d_next;
    logic          ram_ce_reg, ram_ce_next;
    logic          ram_we_reg, ram_we_next;
    logic [7:0]    sdd_ram_reg, sdd_ram_next;
    logic [7:0]    host_di_reg, host_di_next;
    logic          host_ack_reg, host_ack_next;
    logic          z_served_reg, z_served_next;

    logic win_hit;
    logic z_req;
    logic h_req;
    logic z_wins;

    assign win_hit = (SDA[15:AW] == BASE[15:AW]);
    assign RAM_SEL = ~nMREQ & win_hit;
    assign z_req   = RAM_SEL & (~nRD | ~nWR) & ~z_served_reg;
    assign nWAIT   = ~z_req;

    // The host may still hold REQ on the cycle its ACK is visible; masking it there
    // keeps that finished request from being granted a second time.
    assign h_req   = HOST_REQ & ~host_ack_reg;

`ifdef ARB_RR_EN
    logic last_grant_reg, last_grant_next;        // 1: host was served last
    assign z_wins = z_req & (~h_req | last_grant_reg);
`else
    assign z_wins = z_req;
`endif

    // State register
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    // Next-state logic: grant in IDLE, count out the RAM latency, one DONE cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (z_req | h_req) state_next = ACC;
            ACC:     if (cnt_reg <= 3'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath next values for the registered RAM and requester interfaces
    always_comb begin
        cnt_next      = cnt_reg;
        grant_z_next  = grant_z_reg;
        grant_we_next = grant_we_reg;
        ram_a_next    = ram_a_reg;
        ram_d_next    = ram_d_reg;
        ram_ce_next   = 1'b0;
        ram_we_next   = 1'b0;
        sdd_ram_next  = sdd_ram_reg;
        host_di_next  = host_di_reg;
        host_ack_next = 1'b0;
        z_served_next = nMREQ ? 1'b0 : z_served_reg;
`ifdef ARB_RR_EN
        last_grant_next = last_grant_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (z_req | h_req) begin
                    ram_ce_next = 1'b1;
                    cnt_next    = LAT_LOAD;
                    if (z_wins) begin
                        grant_z_next  = 1'b1;
                        grant_we_next = ~nWR;           // nRD and nWR both low => write
                        ram_a_next    = SDA[AW-1:0];
                        ram_d_next    = SDD_OUT;
                        ram_we_next   = ~nWR;
                    end else begin
                        grant_z_next  = 1'b0;
                        grant_we_next = HOST_WE;
                        ram_a_next    = HOST_A;
                        ram_d_next    = HOST_DO;
                        ram_we_next   = HOST_WE;
                    end
                end
            end
            ACC: begin
                cnt_next = cnt_reg - 3'd1;
            end
            DONE: begin
                if (grant_z_reg) begin
                    // An aborted Z80 cycle (nMREQ already high) gets no data and no served flag
                    if (!nMREQ) begin
                        z_served_next = 1'b1;
                        if (!grant_we_reg) sdd_ram_next = RAM_Q;
                    end
                end else begin
                    host_ack_next = 1'b1;
                    if (!grant_we_reg) host_di_next = RAM_Q;
                end
`ifdef ARB_RR_EN
                last_grant_next = ~grant_z_reg;
`endif
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            cnt_reg      <= 3'd0;
            grant_z_reg  <= 1'b0;
            grant_we_reg <= 1'b0;
            ram_a_reg    <= '0;
            ram_d_reg    <= 8'h00;
            ram_ce_reg   <= 1'b0;
            ram_we_reg   <= 1'b0;
            sdd_ram_reg  <= 8'hFF;
            host_di_reg  <= 8'h00;
            host_ack_reg <= 1'b0;
            z_served_reg <= 1'b0;
`ifdef ARB_RR_EN
            last_grant_reg <= 1'b1;
`endif
        end else begin
            cnt_reg      <= cnt_next;
            grant_z_reg  <= grant_z_next;
            grant_we_reg <= grant_we_next;
            ram_a_reg    <= ram_a_next;
            ram_d_reg    <= ram_d_next;
            ram_ce_reg   <= ram_ce_next;
            ram_we_reg   <= ram_we_next;
            sdd_ram_reg  <= sdd_ram_next;
            host_di_reg  <= host_di_next;
            host_ack_reg <= host_ack_next;
            z_served_reg <= z_served_next;
`ifdef ARB_RR_EN
            last_grant_reg <= last_grant_next;
`endif
        end
    end

    assign RAM_A    = ram_a_reg;
    assign RAM_D    = ram_d_reg;
    assign RAM_CE   = ram_ce_reg;
    assign RAM_WE   = ram_we_reg;
    assign SDD_RAM  = sdd_ram_reg;
    assign HOST_DI  = host_di_reg;
    assign HOST_ACK = host_ack_reg;

endmodule

// File: tb/tb_z80_shared_ram_arb.sv
// Bench for z80_shared_ram_arb: behavioural RAM with RAM_LAT read latency, a shadow
// memory image and access-latency arithmetic as the reference; follows ARB_RR_EN.
module tb_z80_shared_ram_arb;
    localparam int          AW   = 11;
    localparam logic [15:0] BASE = 16'hF800;
    localparam int          LAT  = 3;
    localparam int          SOLO = LAT + 2;   // edges from request to completion, uncontested

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   sda;
    logic [7:0]    sdd_out, sdd_ram;
    logic          n_mreq, n_rd, n_wr, ram_sel, n_wait;
    logic          host_req, host_we, host_ack;
    logic [AW-1:0] host_a, ram_a;
    logic [7:0]    host_do, host_di, ram_d, ram_q;
    logic          ram_ce, ram_we;

    int n_checks = 0;
    int n_pass   = 0;
    bit last_host = 1'b1;   // model: who was served last (reset: host)

    logic [7:0]    ram_mem [0:(1<<AW)-1];
    logic [7:0]    shadow  [0:(1<<AW)-1];
    int            ce_count = 0, wr_count = 0, ce_long = 0, q_cnt = 0;
    logic          ce_prev = 1'b0;
    logic [AW-1:0] q_addr, last_ce_addr;

    always #5 clk = ~clk;

    z80_shared_ram_arb #(.AW(AW), .BASE(BASE), .RAM_LAT(LAT)) dut (
        .CLK(clk), .nRESET(rst_n), .SDA(sda), .SDD_OUT(sdd_out), .nMREQ(n_mreq),
        .nRD(n_rd), .nWR(n_wr), .SDD_RAM(sdd_ram), .RAM_SEL(ram_sel), .nWAIT(n_wait),
        .HOST_REQ(host_req), .HOST_WE(host_we), .HOST_A(host_a), .HOST_DO(host_do),
        .HOST_DI(host_di), .HOST_ACK(host_ack), .RAM_A(ram_a), .RAM_D(ram_d),
        .RAM_Q(ram_q), .RAM_CE(ram_ce), .RAM_WE(ram_we)
    );

    // Synchronous RAM: Q valid LAT edges after CE is sampled; inverted data before that
    always @(posedge clk) begin
        if (ram_ce) begin
            ce_count     <= ce_count + 1;
            last_ce_addr <= ram_a;
            if (ce_prev) ce_long <= ce_long + 1;
            if (ram_we) begin
                ram_mem[ram_a] <= ram_d;
                wr_count       <= wr_count + 1;
            end else if (LAT == 1) begin
                ram_q <= ram_mem[ram_a];
            end else begin
                q_addr <= ram_a;
                q_cnt  <= LAT - 1;
                ram_q  <= ~ram_mem[ram_a];
            end
        end else if (q_cnt > 0) begin
            q_cnt <= q_cnt - 1;
            if (q_cnt == 1) ram_q <= ram_mem[q_addr];
        end
        ce_prev <= ram_ce;
    end

    task automatic z80_cycle(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                             output logic [7:0] rd, output int waits, output bit sel);
        @(posedge clk); #1;
        sda = addr; sdd_out = wd; n_mreq = 1'b0; n_rd = we; n_wr = ~we;
        waits = 0;
        @(negedge clk);
        sel = ram_sel;
        while (n_wait === 1'b0 && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        rd = sdd_ram;
        @(posedge clk); #1;
        n_mreq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
    endtask

    task automatic host_xfer(input bit we, input logic [AW-1:0] a, input logic [7:0] d,
                             output logic [7:0] rd, output int waits);
        @(posedge clk); #1;
        host_req = 1'b1; host_we = we; host_a = a; host_do = d;
        waits = 0;
        @(negedge clk);
        while (host_ack !== 1'b1 && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        rd = host_di;
        @(posedge clk); #1;
        host_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; #1; rst_n = 1'b0; #2;
        n_checks++; if (ram_ce !== 1'b0) $display("FAIL rst_ram_ce got %b want 0", ram_ce); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL rst_ram_we got %b want 0", ram_we); else n_pass++;
        n_checks++; if (ram_a !== '0) $display("FAIL rst_ram_a got %h want 000", ram_a); else n_pass++;
        n_checks++; if (ram_d !== 8'h00) $display("FAIL rst_ram_d got %h want 00", ram_d); else n_pass++;
        n_checks++; if (sdd_ram !== 8'hFF) $display("FAIL rst_sdd_ram got %h want ff", sdd_ram); else n_pass++;
        n_checks++; if (host_di !== 8'h00) $display("FAIL rst_host_di got %h want 00", host_di); else n_pass++;
        n_checks++; if (host_ack !== 1'b0) $display("FAIL rst_host_ack got %b want 0", host_ack); else n_pass++;
        n_checks++; if (n_wait !== 1'b1) $display("FAIL rst_nwait got %b want 1", n_wait); else n_pass++;
        sda = 16'hF805; n_mreq = 1'b0; #1;
        n_checks++; if (ram_sel !== 1'b1) $display("FAIL sel_in_window got %b want 1", ram_sel); else n_pass++;
        sda = 16'h1234; #1;
        n_checks++; if (ram_sel !== 1'b0) $display("FAIL sel_outside got %b want 0", ram_sel); else n_pass++;
        sda = 16'hF805; n_mreq = 1'b1; #1;
        n_checks++; if (ram_sel !== 1'b0) $display("FAIL sel_no_mreq got %b want 0", ram_sel); else n_pass++;
        sda = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        last_host = 1'b1;
    endtask

    task automatic test_z80_read();
        logic [7:0] rd; int w; bit s; int ce0;
        host_xfer(1'b1, AW'(5), 8'h3C, rd, w);
        shadow[5] = 8'h3C; last_host = 1'b1;
        n_checks++; if (w !== SOLO) $display("FAIL host_wr_latency got %0d want %0d", w, SOLO); else n_pass++;
        n_checks++; if (ram_mem[5] !== 8'h3C) $display("FAIL host_wr_ram got %h want 3c", ram_mem[5]); else n_pass++;
        ce0 = ce_count;
        z80_cycle(1'b0, 16'hF805, 8'h00, rd, w, s);
        last_host = 1'b0;
        $display("z80 rd F805 -> %h waits=%0d", rd, w);
        n_checks++; if (rd !== 8'h3C) $display("FAIL z80_rd_data got %h want 3c", rd); else n_pass++;
        n_checks++; if (w !== SOLO) $display("FAIL z80_rd_waits got %0d want %0d", w, SOLO); else n_pass++;
        n_checks++; if (s !== 1'b1) $display("FAIL z80_rd_sel got %b want 1", s); else n_pass++;
        n_checks++; if (ce_count - ce0 !== 1) $display("FAIL z80_rd_ce_count got %0d want 1", ce_count - ce0); else n_pass++;
        n_checks++; if (last_ce_addr !== AW'(5)) $display("FAIL z80_rd_ram_a got %h want 005", last_ce_addr); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] hr, zr; int hw, zw; bit zs;
        fork
            host_xfer(1'b1, AW'(11'h7FF), 8'hA5, hr, hw);
            begin
                @(posedge clk);
                z80_cycle(1'b0, 16'hFFFF, 8'h00, zr, zw, zs);
            end
        join
        shadow[11'h7FF] = 8'hA5; last_host = 1'b0;
        $display("host wr 7FF=A5 waits=%0d, z80 rd FFFF -> %h waits=%0d", hw, zr, zw);
        n_checks++; if (hw !== SOLO) $display("FAIL b2b_host_waits got %0d want %0d", hw, SOLO); else n_pass++;
        n_checks++; if (zw !== 2 * SOLO - 1) $display("FAIL b2b_z80_waits got %0d want %0d", zw, 2 * SOLO - 1); else n_pass++;
        n_checks++; if (zr !== 8'hA5) $display("FAIL b2b_z80_data got %h want a5", zr); else n_pass++;
    endtask

    task automatic test_tie();
        logic [7:0] hr, zr; int hw, zw; bit zs, z_first;
        logic [AW-1:0] za, ha;
        for (int r = 0; r < 4; r++) begin
            za = AW'($urandom); ha = AW'($urandom);
            if (r % 2 == 0) begin
                z80_cycle(1'b0, BASE | 16'(za), 8'h00, zr, zw, zs);
                last_host = 1'b0;
            end else begin
                host_xfer(1'b0, ha, 8'h00, hr, hw);
                last_host = 1'b1;
            end
`ifdef ARB_RR_EN
            z_first = last_host;
`else
            z_first = 1'b1;
`endif
            fork
                z80_cycle(1'b0, BASE | 16'(za), 8'h00, zr, zw, zs);
                host_xfer(1'b0, ha, 8'h00, hr, hw);
            join
            last_host = z_first;
            $display("tie %0d: z80 %h waits=%0d, host %h waits=%0d", r, zr, zw, hr, hw);
            n_checks++; if (zw !== (z_first ? SOLO : 2 * SOLO)) $display("FAIL tie_z80_waits r%0d got %0d want %0d", r, zw, z_first ? SOLO : 2 * SOLO); else n_pass++;
            n_checks++; if (hw !== (z_first ? 2 * SOLO : SOLO)) $display("FAIL tie_host_waits r%0d got %0d want %0d", r, hw, z_first ? 2 * SOLO : SOLO); else n_pass++;
            n_checks++; if (zr !== shadow[za]) $display("FAIL tie_z80_data r%0d got %h want %h", r, zr, shadow[za]); else n_pass++;
            n_checks++; if (hr !== shadow[ha]) $display("FAIL tie_host_data r%0d got %h want %h", r, hr, shadow[ha]); else n_pass++;
        end
    endtask

    task automatic test_outside();
        logic [7:0] rd, sdd0; int w; bit s; int ce0;
        sdd0 = sdd_ram; ce0 = ce_count;
        z80_cycle(1'b0, 16'h1234, 8'h00, rd, w, s);
        z80_cycle(1'b1, 16'h1234, 8'h77, rd, w, s);
        $display("z80 outside 1234 waits=%0d sel=%b", w, s);
        n_checks++; if (w !== 0) $display("FAIL outside_waits got %0d want 0", w); else n_pass++;
        n_checks++; if (s !== 1'b0) $display("FAIL outside_sel got %b want 0", s); else n_pass++;
        n_checks++; if (ce_count !== ce0) $display("FAIL outside_ce got %0d want %0d", ce_count, ce0); else n_pass++;
        n_checks++; if (rd !== sdd0) $display("FAIL outside_sdd got %h want %h", rd, sdd0); else n_pass++;
    endtask

    task automatic test_abort();
        logic [AW-1:0] a; logic [7:0] d, rd, sdd0; int wr0, ce0, w; bit s;
        a = AW'($urandom); d = ~shadow[a]; wr0 = wr_count;
        @(posedge clk); #1;
        sda = BASE | 16'(a); sdd_out = d; n_mreq = 1'b0; n_wr = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        n_mreq = 1'b1; n_wr = 1'b1;
        repeat (LAT + 3) @(posedge clk);
        @(negedge clk);
        shadow[a] = d; last_host = 1'b0;
        $display("z80 aborted wr %h=%h", a, d);
        n_checks++; if (wr_count - wr0 !== 1) $display("FAIL abort_wr_count got %0d want 1", wr_count - wr0); else n_pass++;
        n_checks++; if (ram_mem[a] !== d) $display("FAIL abort_wr_data got %h want %h", ram_mem[a], d); else n_pass++;
        n_checks++; if (n_wait !== 1'b1) $display("FAIL abort_nwait got %b want 1", n_wait); else n_pass++;
        z80_cycle(1'b0, BASE | 16'(a), 8'h00, rd, w, s);
        n_checks++; if (w !== SOLO) $display("FAIL abort_next_waits got %0d want %0d", w, SOLO); else n_pass++;
        n_checks++; if (rd !== d) $display("FAIL abort_next_data got %h want %h", rd, d); else n_pass++;
        // aborted read: the RAM cycle runs but SDD_RAM keeps its value
        a = a + AW'(1); sdd0 = sdd_ram; ce0 = ce_count;
        @(posedge clk); #1;
        sda = BASE | 16'(a); n_mreq = 1'b0; n_rd = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        n_mreq = 1'b1; n_rd = 1'b1;
        repeat (LAT + 3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (sdd_ram !== sdd0) $display("FAIL abort_rd_sdd got %h want %h", sdd_ram, sdd0); else n_pass++;
        n_checks++; if (ce_count - ce0 !== 1) $display("FAIL abort_rd_ce got %0d want 1", ce_count - ce0); else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        logic [AW-1:0] a0; logic [7:0] old, rd; int wr0, w;
        a0 = AW'($urandom_range(1, (1 << AW) - 1)); old = shadow[a0]; wr0 = wr_count;
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b1; host_a = a0; host_do = ~old;
        @(posedge clk); #1;
        n_checks++; if (ram_ce !== 1'b1 || ram_a !== a0) $display("FAIL mid_pre_ce got ce=%b a=%h want ce=1 a=%h", ram_ce, ram_a, a0); else n_pass++;
        #2; rst_n = 1'b0; #1;
        n_checks++; if (ram_ce !== 1'b0) $display("FAIL mid_rst_ce got %b want 0", ram_ce); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL mid_rst_we got %b want 0", ram_we); else n_pass++;
        n_checks++; if (ram_a !== '0) $display("FAIL mid_rst_a got %h want 000", ram_a); else n_pass++;
        n_checks++; if (ram_d !== 8'h00) $display("FAIL mid_rst_d got %h want 00", ram_d); else n_pass++;
        n_checks++; if (sdd_ram !== 8'hFF) $display("FAIL mid_rst_sdd got %h want ff", sdd_ram); else n_pass++;
        n_checks++; if (host_di !== 8'h00) $display("FAIL mid_rst_host_di got %h want 00", host_di); else n_pass++;
        host_req = 1'b0; host_we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        last_host = 1'b1;
        n_checks++; if (wr_count !== wr0) $display("FAIL mid_abandoned_wr got %0d want %0d", wr_count, wr0); else n_pass++;
        host_xfer(1'b0, a0, 8'h00, rd, w);
        $display("host rd %h after reset -> %h waits=%0d", a0, rd, w);
        n_checks++; if (w !== SOLO) $display("FAIL mid_after_waits got %0d want %0d", w, SOLO); else n_pass++;
        n_checks++; if (rd !== old) $display("FAIL mid_after_data got %h want %h", rd, old); else n_pass++;
    endtask

    task automatic test_random();
        logic [AW-1:0] a; logic [7:0] d, rd, sdd0; int w, ce0, kind; bit s;
        logic [15:0] oa;
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 4)); a = AW'($urandom); d = 8'($urandom);
            sdd0 = sdd_ram; ce0 = ce_count;
            case (kind)
                0: begin
                    z80_cycle(1'b0, BASE | 16'(a), 8'h00, rd, w, s); last_host = 1'b0;
                    n_checks++; if (rd !== shadow[a] || w !== SOLO) $display("FAIL rnd_z80_rd t%0d got %h/%0d want %h/%0d", t, rd, w, shadow[a], SOLO); else n_pass++;
                end
                1: begin
                    z80_cycle(1'b1, BASE | 16'(a), d, rd, w, s); last_host = 1'b0; shadow[a] = d;
                    n_checks++; if (ram_mem[a] !== d || rd !== sdd0 || w !== SOLO) $display("FAIL rnd_z80_wr t%0d got mem=%h sdd=%h w=%0d want %h/%h/%0d", t, ram_mem[a], rd, w, d, sdd0, SOLO); else n_pass++;
                end
                2: begin
                    host_xfer(1'b0, a, 8'h00, rd, w); last_host = 1'b1;
                    n_checks++; if (rd !== shadow[a] || w !== SOLO) $display("FAIL rnd_host_rd t%0d got %h/%0d want %h/%0d", t, rd, w, shadow[a], SOLO); else n_pass++;
                end
                3: begin
                    host_xfer(1'b1, a, d, rd, w); last_host = 1'b1; shadow[a] = d;
                    n_checks++; if (ram_mem[a] !== d || w !== SOLO) $display("FAIL rnd_host_wr t%0d got %h/%0d want %h/%0d", t, ram_mem[a], w, d, SOLO); else n_pass++;
                end
                default: begin
                    oa = 16'($urandom_range(0, 32'h0000F7FF));
                    z80_cycle(1'b0, oa, 8'h00, rd, w, s);
                    n_checks++; if (w !== 0 || ce_count !== ce0) $display("FAIL rnd_outside t%0d got w=%0d ce=%0d want 0/%0d", t, w, ce_count, ce0); else n_pass++;
                end
            endcase
            $display("txn %0d kind=%0d addr=%h data=%h rd=%h waits=%0d", t, kind, a, d, rd, w);
        end
        n_checks++; if (ce_long !== 0) $display("FAIL ce_single_cycle got %0d long pulses want 0", ce_long); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sda = 16'h0000; sdd_out = 8'h00; n_mreq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
        host_req = 1'b0; host_we = 1'b0; host_a = '0; host_do = 8'h00; ram_q = 8'h00;
        for (int i = 0; i < (1 << AW); i++) begin
            shadow[i]  = 8'($urandom);
            ram_mem[i] = shadow[i];
        end
        test_reset();
        test_z80_read();
        test_back_to_back();
        test_tie();
        test_outside();
        test_abort();
        test_reset_mid_access();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
